// File: rtl/nott_bank.sv
// Bank of WIDTH clocked-inverter (NOTT) or DFF channels with SFQ-style pulse
// inputs, a LATENCY-deep result pipeline and sticky per-channel double-input flags.
module nott_bank #(
  parameter int WIDTH   = 4,
  parameter int INVERT  = 1,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_p,
  input  logic             clk_p,
  input  logic             err_clr,
  output logic [WIDTH-1:0] out_p,
  output logic             out_v,
  output logic [WIDTH-1:0] dbl_err
);

  // Per-channel "data pulse seen since the last clock pulse" state.
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] dbl_err_q, dbl_err_d;

  // out_v is a one-cycle valid strobe with no back-pressure: out_p carries an
  // evaluation result exactly when out_v=1 and is forced to zero otherwise.
  logic [LATENCY-1:0]            pipe_v_q, pipe_v_d;
  logic [LATENCY-1:0][WIDTH-1:0] pipe_p_q, pipe_p_d;

  logic [WIDTH-1:0] dbl_hit;
  logic [WIDTH-1:0] eff;
  logic [WIDTH-1:0] res;

  always_comb begin
    dbl_hit = in_p & s_q;
    eff     = s_q | in_p;
    res     = (INVERT != 0) ? ~eff : eff;

    // A clock pulse consumes every stored pulse, including a coincident one.
    s_d = clk_p ? '0 : (s_q | in_p);

    // A fresh double input outranks a simultaneous clear.
    dbl_err_d = (err_clr ? '0 : dbl_err_q) | dbl_hit;

    pipe_v_d    = '0;
    pipe_p_d    = '0;
    pipe_v_d[0] = clk_p;
    pipe_p_d[0] = clk_p ? res : '0;
    for (int k = 1; k < LATENCY; k++) begin
      pipe_v_d[k] = pipe_v_q[k-1];
      pipe_p_d[k] = pipe_p_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q       <= '0;
      dbl_err_q <= '0;
      pipe_v_q  <= '0;
      pipe_p_q  <= '0;
    end else begin
      s_q       <= s_d;
      dbl_err_q <= dbl_err_d;
      pipe_v_q  <= pipe_v_d;
      pipe_p_q  <= pipe_p_d;
    end
  end

  assign out_v   = pipe_v_q[LATENCY-1];
  assign out_p   = pipe_p_q[LATENCY-1];
  assign dbl_err = dbl_err_q;

endmodule

// File: tb/tb_nott_bank.sv
// Bench for nott_bank: instance a (INVERT=1, LATENCY=2) and instance b
// (INVERT=0, LATENCY=1) share stimulus; directed table plus random run.
module tb_nott_bank;

  logic       clk;
  logic       rst;
  logic [3:0] in_p;
  logic       clk_p;
  logic       err_clr;
  logic [3:0] a_p, b_p, a_dbl, b_dbl;
  logic       a_v, b_v;

  nott_bank #(.WIDTH(4), .INVERT(1), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .in_p(in_p), .clk_p(clk_p), .err_clr(err_clr),
    .out_p(a_p), .out_v(a_v), .dbl_err(a_dbl)
  );

  nott_bank #(.WIDTH(4), .INVERT(0), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .in_p(in_p), .clk_p(clk_p), .err_clr(err_clr),
    .out_p(b_p), .out_v(b_v), .dbl_err(b_dbl)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: pending-result queues keyed by the cycle they are due
  typedef struct {
    int         due;
    logic [3:0] r;
  } pend_t;
  pend_t      pend_a[$];
  pend_t      pend_b[$];
  logic [3:0] held_a, held_b;   // pulses received since last clock pulse
  logic [3:0] dbl_a, dbl_b;

  typedef struct {
    logic       rst;
    logic [3:0] in_p;
    logic       clk_p;
    logic       clr;
    logic       ev;
    logic [3:0] ep;
    logic [3:0] ed;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    pend_a.delete();
    pend_b.delete();
    held_a = '0;
    held_b = '0;
    dbl_a  = '0;
    dbl_b  = '0;
  endtask

  task automatic model_compare();
    logic       ev;
    logic [3:0] ep;
    ev = 1'b0; ep = '0;
    if (pend_a.size() > 0 && pend_a[0].due == cyc) begin
      ev = 1'b1; ep = pend_a[0].r; void'(pend_a.pop_front());
    end
    chk("model_a_v", {31'd0, a_v}, {31'd0, ev});
    chk("model_a_p", {28'd0, a_p}, {28'd0, ep});
    chk("model_a_dbl", {28'd0, a_dbl}, {28'd0, dbl_a});
    ev = 1'b0; ep = '0;
    if (pend_b.size() > 0 && pend_b[0].due == cyc) begin
      ev = 1'b1; ep = pend_b[0].r; void'(pend_b.pop_front());
    end
    chk("model_b_v", {31'd0, b_v}, {31'd0, ev});
    chk("model_b_p", {28'd0, b_p}, {28'd0, ep});
    chk("model_b_dbl", {28'd0, b_dbl}, {28'd0, dbl_b});
  endtask

  // Applies the channel rules for the inputs of the current cycle.
  task automatic model_update(input logic [3:0] in_v, input logic ck, input logic clr);
    pend_t e;
    dbl_a = (clr ? 4'd0 : dbl_a) | (in_v & held_a);
    dbl_b = (clr ? 4'd0 : dbl_b) | (in_v & held_b);
    if (ck) begin
      e.due = cyc + 2; e.r = ~(held_a | in_v); pend_a.push_back(e);
      e.due = cyc + 1; e.r =  (held_b | in_v); pend_b.push_back(e);
      held_a = '0;
      held_b = '0;
    end else begin
      held_a = held_a | in_v;
      held_b = held_b | in_v;
    end
  endtask

  // driver: one cycle of stimulus, outputs checked mid-cycle
  task automatic step(input logic r, input logic [3:0] in_v, input logic ck, input logic clr);
    @(negedge clk);
    rst = r; in_p = in_v; clk_p = ck; err_clr = clr;
    if (r) model_reset();
    #1;
    model_compare();
    if (!r) model_update(in_v, ck, clr);
    cyc++;
  endtask

  task automatic add(input logic r, input logic [3:0] i, input logic c, input logic e,
                     input logic ev, input logic [3:0] ep, input logic [3:0] ed);
    vec_t v;
    v.rst = r; v.in_p = i; v.clk_p = c; v.clr = e; v.ev = ev; v.ep = ep; v.ed = ed;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; in_p = '0; clk_p = 1'b0; err_clr = 1'b0;
    model_reset();

    // reset, then a bare clock pulse
    add(1,4'h0,0,0, 0,4'h0,4'h0); add(1,4'h0,0,0, 0,4'h0,4'h0);
    add(0,4'h0,0,0, 0,4'h0,4'h0); add(0,4'h0,1,0, 0,4'h0,4'h0);
    add(0,4'h0,0,0, 0,4'h0,4'h0); add(0,4'h0,0,0, 1,4'hF,4'h0);
    add(0,4'h0,0,0, 0,4'h0,4'h0);
    // stored pulses then an empty period
    add(1,4'h0,0,0, 0,4'h0,4'h0); add(0,4'h0,0,0, 0,4'h0,4'h0);
    add(0,4'h5,0,0, 0,4'h0,4'h0); add(0,4'h0,0,0, 0,4'h0,4'h0);
    add(0,4'h0,1,0, 0,4'h0,4'h0); add(0,4'h0,0,0, 0,4'h0,4'h0);
    add(0,4'h0,0,0, 1,4'hA,4'h0); add(0,4'h0,1,0, 0,4'h0,4'h0);
    add(0,4'h0,0,0, 0,4'h0,4'h0); add(0,4'h0,0,0, 1,4'hF,4'h0);
    add(0,4'h0,0,0, 0,4'h0,4'h0);
    // coincident pulse, then back-to-back clock pulses
    add(1,4'h0,0,0, 0,4'h0,4'h0); add(0,4'h0,0,0, 0,4'h0,4'h0);
    add(0,4'h0,0,0, 0,4'h0,4'h0); add(0,4'h1,1,0, 0,4'h0,4'h0);
    add(0,4'h0,1,0, 0,4'h0,4'h0); add(0,4'h0,1,0, 1,4'hE,4'h0);
    add(0,4'h0,1,0, 1,4'hF,4'h0); add(0,4'h0,0,0, 1,4'hF,4'h0);
    add(0,4'h0,0,0, 1,4'hF,4'h0); add(0,4'h0,0,0, 0,4'h0,4'h0);
    // double input, set-beats-clear, clear alone
    add(1,4'h0,0,0, 0,4'h0,4'h0); add(0,4'h0,0,0, 0,4'h0,4'h0);
    add(0,4'h4,0,0, 0,4'h0,4'h0); add(0,4'h4,0,0, 0,4'h0,4'h0);
    add(0,4'h0,1,0, 0,4'h0,4'h4); add(0,4'h0,0,0, 0,4'h0,4'h4);
    add(0,4'h0,0,0, 1,4'hB,4'h4); add(0,4'h4,0,0, 0,4'h0,4'h4);
    add(0,4'h4,0,1, 0,4'h0,4'h4); add(0,4'h0,0,0, 0,4'h0,4'h4);
    add(0,4'h0,0,1, 0,4'h0,4'h4); add(0,4'h0,0,0, 0,4'h0,4'h0);
    // reset with an evaluation in flight and a flag set
    add(1,4'h0,0,0, 0,4'h0,4'h0); add(0,4'h2,0,0, 0,4'h0,4'h0);
    add(0,4'h2,0,0, 0,4'h0,4'h0); add(0,4'h0,1,0, 0,4'h0,4'h2);
    add(1,4'h0,0,0, 0,4'h0,4'h0); add(0,4'h0,0,0, 0,4'h0,4'h0);
    add(0,4'h0,0,0, 0,4'h0,4'h0);
    // inputs during reset are ignored
    add(1,4'hF,1,0, 0,4'h0,4'h0); add(0,4'h0,1,0, 0,4'h0,4'h0);
    add(0,4'h0,0,0, 0,4'h0,4'h0); add(0,4'h0,0,0, 1,4'hF,4'h0);
    add(0,4'h0,0,0, 0,4'h0,4'h0);

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].in_p, tbl[k].clk_p, tbl[k].clr);
      chk($sformatf("tbl%0d_v", k),   {31'd0, a_v},   {31'd0, tbl[k].ev});
      chk($sformatf("tbl%0d_p", k),   {28'd0, a_p},   {28'd0, tbl[k].ep});
      chk($sformatf("tbl%0d_dbl", k), {28'd0, a_dbl}, {28'd0, tbl[k].ed});
    end

    // non-inverting, single-stage instance
    step(1, 4'h0, 0, 0);
    step(0, 4'h0, 0, 0);
    step(0, 4'h3, 0, 0);
    step(0, 4'h0, 1, 0);
    step(0, 4'h0, 0, 0);
    chk("b_dff_v", {31'd0, b_v}, 32'd1);
    chk("b_dff_p", {28'd0, b_p}, 32'h3);
    step(0, 4'h0, 1, 0);
    chk("b_gap_v", {31'd0, b_v}, 32'd0);
    step(0, 4'h0, 0, 0);
    chk("b_empty_v", {31'd0, b_v}, 32'd1);
    chk("b_empty_p", {28'd0, b_p}, 32'h0);

    // randomized run against the model
    for (int n = 0; n < 600; n++) begin
      logic       r;
      logic [3:0] iv;
      r  = ($urandom_range(0, 49) == 0);
      iv = ($urandom_range(0, 2) == 0) ? 4'(($urandom_range(0, 15))) : 4'h0;
      step(r, iv, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    end
    step(0, 4'h0, 0, 0);
    step(0, 4'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nott_bank.md
NOTT_BANK -- requirements
Module: nott_bank

Interface
REQ-001 Parameter WIDTH, default 4, number of independent clocked-inverter channels, legal range 1..32.
REQ-002 Parameter INVERT, default 1, 1 = NOTT (inverting) evaluation, 0 = DFF (non-inverting) evaluation, applied to all channels.
REQ-003 Parameter LATENCY, default 1, clk-to-out delay in clk cycles from evaluation to out_p, legal range 1..4.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_p  input  WIDTH  per-channel SFQ data pulse, one-cycle strobe, 1 = one pulse.
REQ-007 clk_p  input  1  SFQ clock pulse strobe, one-cycle, triggers evaluation of all channels.
REQ-008 err_clr  input  1  clears all dbl_err bits.
REQ-009 out_p  output  WIDTH  per-channel output pulse, one-cycle strobe.
REQ-010 out_v  output  1  high for exactly the cycle in which an evaluation result is presented on out_p.
REQ-011 dbl_err  output  WIDTH  sticky per-channel double-input flag.

Function
REQ-012 Each channel holds one state bit s[i] meaning "data pulse received since last clock pulse".
REQ-013 in_p[i]=1 with clk_p=0 sets s[i] to 1.
REQ-014 On clk_p=1, each channel evaluates eff[i] = s[i] OR in_p[i]; a coincident in_p belongs to the period being closed.
REQ-015 Result r[i] = NOT eff[i] when INVERT=1; r[i] = eff[i] when INVERT=0.
REQ-016 On clk_p=1, s[i] is cleared to 0 for every channel, including channels with coincident in_p (pulse consumed).
REQ-017 Results enter a LATENCY-stage pipeline; r plus a valid bit appear on out_p/out_v exactly LATENCY cycles after the clk_p cycle.
REQ-018 out_p SHALL be all-zero whenever out_v=0.
REQ-019 clk_p on consecutive cycles SHALL produce out_v on consecutive cycles with no dropped evaluation (pipeline fully throughput-1).
REQ-020 in_p[i]=1 while s[i]=1 (with or without clk_p) is a double input: dbl_err[i] sets to 1, s[i] remains/evaluates as 1, extra pulse discarded.
REQ-021 dbl_err bits are sticky until err_clr=1; when a set and err_clr occur in the same cycle, the set wins for that bit.
REQ-022 in_p with no subsequent clk_p SHALL leave s[i]=1 indefinitely; no output is generated without clk_p.
REQ-023 out_p/out_v are registered outputs; no combinational path from any input to any output.

Reset
REQ-024 rst=1 SHALL immediately (asynchronously) force s=0, all pipeline stages invalid, out_p=0, out_v=0, dbl_err=0.
REQ-025 Evaluations in flight when rst asserts SHALL be discarded and never appear on out_p after rst deasserts.
REQ-026 in_p and clk_p SHALL be ignored in any cycle in which rst=1.
REQ-027 First clk_p after reset with no in_p SHALL yield out_p = all ones (INVERT=1) or all zeros with out_v=1 (INVERT=0).

Verification (WIDTH=4, LATENCY=2 unless stated)
REQ-028 INVERT=1: reset, no in_p, clk_p at cycle 3 -> out_v=1, out_p=4'b1111 at cycle 5 only.
REQ-029 INVERT=1: in_p=4'b0101 at cycle 2, clk_p at cycle 4 -> out_p=4'b1010 at cycle 6; next clk_p at cycle 7 with no input -> 4'b1111 at cycle 9.
REQ-030 INVERT=1: in_p=4'b0001 coincident with clk_p at cycle 3 -> out_p=4'b1110 at cycle 5; clk_p at cycles 4,5,6 -> 4'b1111 at cycles 6,7,8 back-to-back.
REQ-031 INVERT=1: in_p=4'b0100 at cycles 2 and 3, clk_p at 4 -> dbl_err=4'b0100 from cycle 4, out_p=4'b1011 at cycle 6; err_clr with new double on bit 2 same cycle -> dbl_err stays 4'b0100; err_clr alone -> 4'b0000.
REQ-032 clk_p at cycle 3, rst pulsed in cycle 4 -> out_v never asserts for that evaluation; out_p=0, dbl_err=0 during rst.
REQ-033 INVERT=0, LATENCY=1: in_p=4'b0011 at cycle 2, clk_p at cycle 3 -> out_p=4'b0011, out_v=1 at cycle 4.
